// File: rtl/nsu_pkg.sv
// Shared constants, FSM encoding and helpers for the NSU drain scheduler slice.
package nsu_pkg;

  localparam int VIRTUAL_CH_NUM = 16;
  localparam int FLIT_NUM_MAX   = 16;
  localparam int VC_IDX_W       = $clog2(VIRTUAL_CH_NUM);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CMD   = 4'b0010,
    S_DRAIN = 4'b0100,
    S_DONE  = 4'b1000
  } state_e;

  // Index of the highest set bit; callers check one-hotness separately.
  function automatic logic [VC_IDX_W-1:0] onehot_to_index(input logic [VIRTUAL_CH_NUM-1:0] vec);
    logic [VC_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < VIRTUAL_CH_NUM; i++) begin
      if (vec[i]) idx = VC_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/nsu_drain_skid.sv
// Two-entry fall-through skid buffer: an incoming beat is presented the same
// cycle it arrives and is only stored when it cannot be handed straight on.
module nsu_drain_skid #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] mem_data_q [2];
  logic [1:0]            mem_last_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q;
  logic                  stored;
  logic                  push;
  logic                  pop;

  assign stored    = (occ_q != 2'd0);
  assign pop       = stored && out_ready;
  // Stored entries are older than the arriving beat, so it must queue behind them.
  assign push      = in_valid && (stored || !out_ready);
  assign out_valid = stored || in_valid;
  assign out_data  = stored ? mem_data_q[rd_ptr_q] : (in_valid ? in_data : '0);
  assign out_last  = stored ? mem_last_q[rd_ptr_q] : (in_valid && in_last);
  assign occupancy = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data_q[0] <= '0;
      mem_data_q[1] <= '0;
      mem_last_q    <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q] <= in_data;
        mem_last_q[wr_ptr_q] <= in_last;
        wr_ptr_q             <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/nsu_vc_drain_scheduler.sv
// Drains per-packet VC FIFOs in packet order after a NoC transaction completes,
// producing one AXI command record and an in-order beat stream.
module nsu_vc_drain_scheduler
  import nsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int ID_WIDTH       = 4
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      nocpack_done,
  input  logic [VIRTUAL_CH_NUM-1:0] pack_num,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_addr,
  input  logic [7:0]                axi_len,
  input  logic [2:0]                axi_type,
  input  logic [ID_WIDTH-1:0]       source_id,
  input  logic [VIRTUAL_CH_NUM-1:0] empty_vc,
  output logic [VIRTUAL_CH_NUM-1:0] rd_en,
  input  logic [DATA_WIDTH-1:0]     data_out,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]                cmd_len,
  output logic [2:0]                cmd_type,
  output logic [ID_WIDTH-1:0]       cmd_id,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      busy,
  output logic                      trans_done,
  output logic                      len_err,
  output logic [3:0]                dbg_state
);

  // Handshakes (cmd_*, m_*): a transfer happens on a cycle with valid && ready;
  // once valid is raised, it and its payload hold until that transfer.

  state_e                    state_q;
  logic [VIRTUAL_CH_NUM-1:0] pn_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [2:0]                type_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic                      len_err_q;
  logic [VC_IDX_W-1:0]       k_q;
  logic [4:0]                quota_q;
  logic [8:0]                issued_q;
  logic [8:0]                accepted_q;
  logic                      infl_q;
  logic                      infl_last_q;
  logic                      trans_done_q;

  logic [8:0] total_beats;
  logic [8:0] pkts_needed;
  logic [8:0] pkts_claimed;
  logic       pkt_mismatch;
  logic [1:0] occ;
  logic       rd_fire;
  logic       last_read;
  logic       quota_full;
  logic       beat_fire;

  assign total_beats  = {1'b0, len_q} + 9'd1;
  assign pkts_needed  = (total_beats + 9'(FLIT_NUM_MAX - 1)) / 9'(FLIT_NUM_MAX);
  assign pkts_claimed = 9'(onehot_to_index(pn_q)) + 9'd1;
  assign pkt_mismatch = !$onehot(pn_q) || (pkts_needed != pkts_claimed);

  // A read is only issued when the skid can absorb it alongside the beat already in flight.
  assign rd_fire    = (state_q == S_DRAIN) && !empty_vc[k_q] && (issued_q != total_beats) &&
                      (({1'b0, occ} + {2'b0, infl_q}) < 3'd2);
  assign last_read  = ((issued_q + 9'd1) == total_beats);
  assign quota_full = (quota_q == 5'(FLIT_NUM_MAX - 1));
  assign beat_fire  = m_valid && m_ready;

  assign rd_en      = rd_fire ? (VIRTUAL_CH_NUM'(1) << k_q) : '0;
  assign cmd_valid  = (state_q == S_CMD);
  assign busy       = (state_q != S_IDLE);
  assign cmd_addr   = addr_q;
  assign cmd_len    = len_q;
  assign cmd_type   = type_q;
  assign cmd_id     = id_q;
  assign trans_done = trans_done_q;
  assign len_err    = len_err_q;
  assign dbg_state  = state_q;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q      <= S_IDLE;
      pn_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      type_q       <= '0;
      id_q         <= '0;
      len_err_q    <= 1'b0;
      k_q          <= '0;
      quota_q      <= '0;
      issued_q     <= '0;
      accepted_q   <= '0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      trans_done_q <= 1'b0;
    end else begin
      trans_done_q <= 1'b0;
      infl_q       <= rd_fire;
      infl_last_q  <= rd_fire && last_read;
      if (beat_fire) accepted_q <= accepted_q + 9'd1;
      case (state_q)
        S_IDLE: begin
          if (nocpack_done) begin
            pn_q       <= pack_num;
            addr_q     <= axi_addr;
            len_q      <= axi_len;
            type_q     <= axi_type;
            id_q       <= source_id;
            len_err_q  <= 1'b0;
            k_q        <= '0;
            quota_q    <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            state_q    <= S_CMD;
          end
        end
        S_CMD: begin
          if (pkt_mismatch) len_err_q <= 1'b1;
          if (cmd_ready) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (rd_fire) begin
            issued_q <= issued_q + 9'd1;
            if (last_read) begin
              state_q <= S_DONE;
            end else if (quota_full) begin
              quota_q <= '0;
              // Length beyond the last VC: keep draining the last one and flag it.
              if (k_q == VC_IDX_W'(VIRTUAL_CH_NUM - 1)) len_err_q <= 1'b1;
              else k_q <= k_q + 1'b1;
            end else begin
              quota_q <= quota_q + 5'd1;
            end
          end
        end
        S_DONE: begin
          if ((accepted_q + {8'd0, beat_fire}) == total_beats) begin
            trans_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  nsu_drain_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (noc_clk),
    .rst_n    (noc_rst_n),
    .in_valid (infl_q),
    .in_data  (data_out),
    .in_last  (infl_last_q),
    .out_valid(m_valid),
    .out_data (m_data),
    .out_last (m_last),
    .out_ready(m_ready),
    .occupancy(occ)
  );

endmodule

// File: doc/nsu_vc_drain_scheduler.md
Name: nsu_vc_drain_scheduler

Overview:
- Sits directly downstream of the NSU reorder stage, upstream of the NSU AXI master.
- After a NoC transaction's first tail-completion pulse, drains the per-order virtual-channel FIFOs strictly in packet order (VC0, VC1, …).
- Emits one AXI command record plus an in-order data beat stream with valid/ready and last.
- Restores original beat order regardless of NoC packet arrival order.

Parameters:
- DATA_WIDTH, 128, flit/beat width.
- AXI_ADDR_WIDTH, 32, address width.
- ID_WIDTH, 4, source ID width.
- VIRTUAL_CH_NUM, 16, number of VC FIFOs; one packet per VC, VC index = packet order.
- FLIT_NUM_MAX, 16, data beats per full packet; last packet carries the remainder.
- VC_IDX_W, $clog2(VIRTUAL_CH_NUM), VC index width.

Ports:
- noc_clk  in  1  clock
- noc_rst_n  in  1  async active-low reset
- nocpack_done  in  1  one-cycle pulse: a packet's tail was accepted and sideband below is valid
- pack_num  in  VIRTUAL_CH_NUM  one-hot total packet count; bit N-1 set means N packets
- axi_addr  in  AXI_ADDR_WIDTH  transaction address
- axi_len  in  8  AXI length; beats = axi_len+1
- axi_type  in  3  transaction type
- source_id  in  ID_WIDTH  originating NMU ID
- empty_vc  in  VIRTUAL_CH_NUM  per-VC FIFO empty
- rd_en  out  VIRTUAL_CH_NUM  per-VC FIFO read strobe; at most one bit set
- data_out  in  DATA_WIDTH  muxed FIFO read data; valid 1 cycle after rd_en (standard FIFO, not FWFT)
- cmd_valid  out  1  command record valid
- cmd_ready  in  1  command accepted
- cmd_addr / cmd_len / cmd_type / cmd_id  out  AXI_ADDR_WIDTH / 8 / 3 / ID_WIDTH  latched sideband
- m_data  out  DATA_WIDTH  beat data
- m_valid  out  1  beat valid
- m_ready  in  1  beat accepted
- m_last  out  1  final beat of transaction
- busy  out  1  state != S_IDLE
- trans_done  out  1  one-cycle pulse when transaction fully drained
- len_err  out  1  sticky until next transaction start; packet count inconsistent with length

Behaviour:
- Reset: all outputs 0, state S_IDLE, counters 0, skid buffer empty.
- FSM:
  - S_IDLE: on nocpack_done, latch pack_num, axi_addr, axi_len, axi_type, source_id; clear len_err; go to S_CMD. nocpack_done outside S_IDLE is ignored.
  - S_CMD: cmd_valid=1 with latched fields; on cmd_ready go to S_DRAIN. Also compute N = index(pack_num)+1. Set len_err if ceil((len+1)/FLIT_NUM_MAX) != N, or if pack_num is not one-hot (treat as N=1). Draining proceeds per length regardless of len_err.
  - S_DRAIN: per VC k, quota = min(FLIT_NUM_MAX, remaining). Assert rd_en[k] when !empty_vc[k], quota not yet issued, and skid occupancy + reads in flight < 2. If empty_vc[k], stall (packet k not yet arrived). When VC k's quota has been issued, advance k; no bubble required. Go to S_DONE when all axi_len+1 reads are issued.
  - S_DONE: wait until the skid buffer is empty and the last beat is accepted; pulse trans_done for 1 cycle; return to S_IDLE.
- Data path:
  - Read data is captured the cycle after rd_en into a 2-entry skid buffer driving m_*.
  - Sustains 1 beat/cycle with m_ready held high.
  - m_data/m_valid/m_last are stable while m_valid && !m_ready.
  - m_last is set on beat index axi_len.
- Counters:
  - 9-bit issued/accepted beat counters (max 256).
  - 5-bit per-VC quota counter.
  - k wraps never; k ≤ N-1 by construction. If len requires k ≥ VIRTUAL_CH_NUM, clamp k, set len_err, and continue reading that VC.
- Latency: nocpack_done → cmd_valid 1 cycle; cmd handshake → first rd_en 1 cycle; rd_en → m_valid 1 cycle.
- Simultaneous events:
  - cmd_ready and nocpack_done in the same cycle: nocpack_done is ignored.
  - A beat accepted in the same cycle as a new read return: occupancy is unchanged.
- Reset mid-operation: state, rd_en, and buffer clear asynchronously; no partial beat emitted after release.

Decomposition:
- Shared package nsu_pkg: FSM state encodings (one-hot S_IDLE/S_CMD/S_DRAIN/S_DONE), FLIT_NUM_MAX, VIRTUAL_CH_NUM, and a onehot_to_index function.
- Sub-module nsu_drain_skid: 2-entry skid buffer with occupancy output; the scheduler uses occupancy for read credits.

Test Plan:
- Single packet, axi_len=7, pack_num=16'h0001, m_ready=1: cmd_addr/len match; 8 rd_en[0] strobes; 8 beats in order, m_last on 8th; trans_done 1 cycle later; len_err=0.
- Three packets, axi_len=39, pack_num=16'h0004: reads VC0×16, VC1×16, VC2×8 in that order; 40 beats; m_last on beat 39.
- Out-of-order arrival: VC1 filled before VC0, empty_vc[0]=1 for 20 cycles: no rd_en[1] until VC0's 16 beats are read; output order still VC0 then VC1.
- Backpressure, m_ready toggling 1010…, axi_len=15: no lost or duplicated beat; m_data stable during stalls; at most 2 reads outstanding.
- Inconsistency, axi_len=15 with pack_num=16'h0002: len_err=1; 16 beats from VC0 only; trans_done pulses.
- Reset asserted mid-drain after 5 beats: all outputs 0 immediately; after release, new nocpack_done starts a clean transaction.
